reg_arbiter: RTL and testbench
==============================

Name: reg_arbiter

Overview:
- Owns the SID-style register file that sits behind the SPI slave.
- Arbitrates one single-port register array between three requesters: SPI writes, the voice engine's read requests, and background refresh of the SPI read-back byte.
- Sits between the spi block (reg_addr/reg_wdata/reg_we/reg_rdata) and the voice/filter engine.
- Guarantees bounded latency to the engine and never loses an SPI write under legal SPI timing.

Parameters:
NUM_REGS, 32, number of implemented 8-bit registers; addresses >= NUM_REGS are unmapped
ADDR_W, 7, address width (matches SPI 7-bit register address)

Ports:
clk_i  in  1  system clock (50 MHz)
rst_ni  in  1  asynchronous active-low reset
spi_addr_i  in  ADDR_W  SPI register address (from spi reg_addr_o)
spi_wdata_i  in  8  SPI write data (from spi reg_wdata_o)
spi_we_i  in  1  single-cycle write strobe (from spi reg_we_o)
spi_rdata_o  out  8  read-back byte for SPI (to spi reg_rdata_i)
eng_req_i  in  1  engine read request; held with eng_addr_i stable until granted
eng_addr_i  in  ADDR_W  engine read address
eng_gnt_o  out  1  request accepted this cycle (combinational from arbitration state)
eng_rvalid_o  out  1  eng_rdata_o valid, one cycle after eng_gnt_o
eng_rdata_o  out  8  engine read data
ovr_o  out  1  sticky: SPI write overrun occurred

Behaviour:
- Reset (async, rst_ni low):
  - All registers 0x00; pending buffer empty; starvation flag clear.
  - spi_rdata_o = 0x00, eng_gnt_o = 0, eng_rvalid_o = 0, eng_rdata_o = 0x00, ovr_o = 0.
- Storage: NUM_REGS x 8, exactly one access (read or write) per cycle.
- Unmapped addresses: writes ignored; reads return 0x00.
- Pending write buffer (1 deep: addr, data, valid):
  - spi_we_i captures spi_addr_i/spi_wdata_i into the buffer at the clock edge.
  - If spi_we_i arrives while valid=1 and the buffer is not committing that same cycle: buffer overwritten (newest wins), ovr_o set to 1 until reset.
  - If spi_we_i arrives in the same cycle the buffer commits: commit the old entry, capture the new one, no overrun.
- Slot arbitration, evaluated each cycle, first match wins:
  1. Engine request and starve=1 -> engine read.
  2. Pending valid -> commit write; if eng_req_i also high, set starve=1.
  3. eng_req_i -> engine read; starve cleared.
  4. Idle -> refresh: spi_rdata_o <= mem[spi_addr_i] (0x00 if unmapped).
- Starvation bound:
  - The engine waits at most 1 cycle for a grant.
  - A pending write waits at most 2 cycles for commit.
  - starve clears whenever the engine is granted.
- Engine read:
  - eng_gnt_o = 1 in the slot cycle.
  - Next cycle: eng_rvalid_o = 1 (single-cycle pulse), eng_rdata_o = data.
  - eng_rdata_o holds its value until the next rvalid.
  - Back-to-back grants are allowed: with eng_req_i continuously high and no writes, gnt fires every cycle.
- Forwarding: an engine read whose address matches a valid pending write not yet committed returns the pending data, not the stale array value.
- spi_rdata_o:
  - Updated only in refresh cycles; latency 1 cycle from the address in an idle system.
  - Also forwarded: if the refresh address matches the pending buffer... (not applicable, since refresh occurs only when the buffer is empty).
- Write commit: takes effect at the clock edge; a read of the same address in the following cycle sees the new value.
- Engine dropping eng_req_i before grant is legal; no read is performed and no rvalid is produced.

Test Plan:
- Reset: assert rst_ni=0 mid-write with pending valid -> all outputs 0, ovr_o=0; after release, engine read of addr 0x05 returns 0x00 (write discarded).
- SPI write 0x12 to 0x04, idle, then set spi_addr_i=0x04 -> spi_rdata_o=0x12 within 2 cycles; write to 0x40 (unmapped), read 0x40 -> 0x00.
- Simultaneous spi_we_i (0x01<-0xAA) and eng_req_i (addr 0x01) -> write commits cycle 1, engine granted cycle 2 with forwarded or committed 0xAA, rvalid cycle 3; grant never later than 2 cycles after req.
- Engine holds eng_req_i while spi_we_i pulses every 2 cycles for 20 cycles -> engine grants alternate with commits; no gnt gap longer than 1 cycle; every write present in the array afterwards.
- Two spi_we_i 1 cycle apart while engine starve forces an engine slot (0x02<-0x11 then 0x03<-0x22) -> ovr_o=1, addr 0x03 holds 0x22, addr 0x02 unchanged.
- Engine streaming reads of 0x00..0x1F, no SPI traffic -> 32 consecutive gnt cycles, rvalid each following cycle, data matches a preloaded pattern.

Source files
------------

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - single-port register file arbiter for SPI writes, engine reads and SPI read-back refresh
//
// Owns NUM_REGS x 8-bit registers. Exactly one array access per cycle, chosen by priority:
// starved engine read, pending SPI write commit, engine read, then SPI read-back refresh.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   spi_addr_i, spi_wdata_i, spi_we_i  SPI register write (single-cycle strobe) and read-back address
//   spi_rdata_o                        SPI read-back byte, updated in refresh cycles
//   eng_req_i, eng_addr_i              engine read request, held until granted
//   eng_gnt_o                          engine read accepted this cycle
//   eng_rvalid_o, eng_rdata_o          engine read data, valid one cycle after grant
//   ovr_o                              sticky SPI write overrun flag
module reg_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [7:0]        spi_wdata_i,
  input  logic              spi_we_i,
  output logic [7:0]        spi_rdata_o,
  input  logic              eng_req_i,
  input  logic [ADDR_W-1:0] eng_addr_i,
  output logic              eng_gnt_o,
  output logic              eng_rvalid_o,
  output logic [7:0]        eng_rdata_o,
  output logic              ovr_o
);

  localparam int              IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_A;
  endfunction

  logic [7:0]        mem_q [NUM_REGS];

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
  logic [7:0]        pend_data_q,  pend_data_d;
  logic              starve_q,     starve_d;
  logic              ovr_q,        ovr_d;
  logic [7:0]        spi_rdata_q,  spi_rdata_d;
  logic              eng_rvalid_q, eng_rvalid_d;
  logic [7:0]        eng_rdata_q,  eng_rdata_d;

  logic              eng_slot;
  logic              commit;
  logic              refresh;
  logic [7:0]        eng_data;
  logic [7:0]        spi_data;

  // Slot selection. A starved engine beats a pending write; otherwise a pending
  // write goes first and marks the engine starved so it wins the next cycle.
  always_comb begin
    eng_slot = eng_req_i && (starve_q || !pend_valid_q);
    commit   = pend_valid_q && !eng_slot;
    refresh  = !eng_req_i && !pend_valid_q;
  end

  // Engine read data. A pending write to the same address forwards its data,
  // since the array still holds the stale value until commit.
  always_comb begin
    eng_data = 8'h00;
    if (is_mapped(eng_addr_i)) begin
      if (pend_valid_q && (pend_addr_q == eng_addr_i)) begin
        eng_data = pend_data_q;
      end else begin
        eng_data = mem_q[eng_addr_i[IDX_W-1:0]];
      end
    end
  end

  // Refresh only runs with the buffer empty, so no forwarding is needed here.
  always_comb begin
    spi_data = 8'h00;
    if (is_mapped(spi_addr_i)) begin
      spi_data = mem_q[spi_addr_i[IDX_W-1:0]];
    end
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    starve_d     = starve_q;
    ovr_d        = ovr_q;
    spi_rdata_d  = spi_rdata_q;
    eng_rvalid_d = eng_slot;
    eng_rdata_d  = eng_rdata_q;

    // A new write in the same cycle as a commit refills the buffer cleanly;
    // only a write landing on an uncommitted entry is an overrun.
    if (spi_we_i) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = spi_addr_i;
      pend_data_d  = spi_wdata_i;
      if (pend_valid_q && !commit) begin
        ovr_d = 1'b1;
      end
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end

    if (eng_slot) begin
      starve_d = 1'b0;
    end else if (commit && eng_req_i) begin
      starve_d = 1'b1;
    end

    if (eng_slot) begin
      eng_rdata_d = eng_data;
    end

    if (refresh) begin
      spi_rdata_d = spi_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= 8'h00;
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= 8'h00;
      starve_q     <= 1'b0;
      ovr_q        <= 1'b0;
      spi_rdata_q  <= 8'h00;
      eng_rvalid_q <= 1'b0;
      eng_rdata_q  <= 8'h00;
    end else begin
      if (commit && is_mapped(pend_addr_q)) begin
        mem_q[pend_addr_q[IDX_W-1:0]] <= pend_data_q;
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      starve_q     <= starve_d;
      ovr_q        <= ovr_d;
      spi_rdata_q  <= spi_rdata_d;
      eng_rvalid_q <= eng_rvalid_d;
      eng_rdata_q  <= eng_rdata_d;
    end
  end

  assign spi_rdata_o  = spi_rdata_q;
  assign eng_gnt_o    = eng_slot;
  assign eng_rvalid_o = eng_rvalid_q;
  assign eng_rdata_o  = eng_rdata_q;
  assign ovr_o        = ovr_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// tb/tb_reg_arbiter.sv - directed self-checking bench for reg_arbiter
module tb_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_we;
  logic [7:0] spi_rdata;
  logic       eng_req;
  logic [6:0] eng_addr;
  logic       eng_gnt;
  logic       eng_rvalid;
  logic [7:0] eng_rdata;
  logic       ovr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_arbiter #(.NUM_REGS(32), .ADDR_W(7)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spi_addr_i   (spi_addr),
    .spi_wdata_i  (spi_wdata),
    .spi_we_i     (spi_we),
    .spi_rdata_o  (spi_rdata),
    .eng_req_i    (eng_req),
    .eng_addr_i   (eng_addr),
    .eng_gnt_o    (eng_gnt),
    .eng_rvalid_o (eng_rvalid),
    .eng_rdata_o  (eng_rdata),
    .ovr_o        (ovr)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5) ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    spi_addr  = a;
    spi_wdata = d;
    spi_we    = 1'b1;
    tick();
    spi_we    = 1'b0;
  endtask

  task automatic eng_read(input logic [6:0] a, input logic [7:0] exp, input string tag);
    logic got;
    got      = 1'b0;
    eng_req  = 1'b1;
    eng_addr = a;
    for (int k = 0; k < 4 && !got; k++) begin
      #1;
      got = eng_gnt;
      tick();
    end
    eng_req = 1'b0;
    if (!got) begin
      chk({tag, "_grant_timeout"}, 8'(got), 8'd1);
    end else begin
      chk({tag, "_rvalid"}, 8'(eng_rvalid), 8'd1);
      chk(tag, eng_rdata, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    spi_addr  = '0;
    spi_wdata = '0;
    spi_we    = 1'b0;
    eng_req   = 1'b0;
    eng_addr  = '0;
    #1 rst_n  = 1'b0;
    tick();
    tick();
    chk("rst_spi_rdata", spi_rdata, 8'h00);
    chk("rst_gnt", 8'(eng_gnt), 8'd0);
    chk("rst_rvalid", 8'(eng_rvalid), 8'd0);
    chk("rst_eng_rdata", eng_rdata, 8'h00);
    chk("rst_ovr", 8'(ovr), 8'd0);
    rst_n = 1'b1;
    tick();

    // Preload with back-to-back writes: each commits while the next is captured.
    for (int i = 0; i < 32; i++) begin
      spi_addr  = 7'(i);
      spi_wdata = pat(i);
      spi_we    = 1'b1;
      tick();
    end
    spi_we = 1'b0;
    tick();
    chk("preload_ovr", 8'(ovr), 8'd0);

    // Streaming engine reads: a grant every cycle, data one cycle later.
    eng_req  = 1'b1;
    eng_addr = 7'd0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("stream_gnt", 8'(eng_gnt), 8'd1);
      tick();
      if (i == 31) eng_req = 1'b0;
      else         eng_addr = 7'(i + 1);
      chk("stream_rvalid", 8'(eng_rvalid), 8'd1);
      chk("stream_data", eng_rdata, pat(i));
    end
    tick();
    chk("stream_rvalid_end", 8'(eng_rvalid), 8'd0);

    // Read-back refresh: commit edge, then refresh edge.
    spi_write(7'h04, 8'h12);
    tick();
    tick();
    chk("refresh_0x04", spi_rdata, 8'h12);
    spi_addr = 7'h00;
    tick();
    chk("refresh_lat1", spi_rdata, pat(0));

    // Unmapped write is dropped and must not alias onto 0x00.
    spi_write(7'h40, 8'h77);
    tick();
    tick();
    chk("refresh_unmapped", spi_rdata, 8'h00);
    eng_read(7'h00, pat(0), "no_alias_0x00");
    eng_read(7'h20, 8'h00, "unmapped_0x20");
    eng_read(7'h40, 8'h00, "unmapped_0x40");

    // Engine request arrives while a write is pending: commit first, then grant.
    spi_write(7'h01, 8'hAA);
    eng_req  = 1'b1;
    eng_addr = 7'h01;
    #1;
    chk("wr_first_gnt", 8'(eng_gnt), 8'd0);
    tick();
    #1;
    chk("starved_gnt", 8'(eng_gnt), 8'd1);
    tick();
    eng_req = 1'b0;
    chk("starved_rvalid", 8'(eng_rvalid), 8'd1);
    chk("starved_data", eng_rdata, 8'hAA);

    // Engine held, write every 2 cycles: grants alternate with commits.
    eng_req  = 1'b1;
    eng_addr = 7'h10;
    for (int c = 0; c < 20; c++) begin
      spi_we    = ((c % 2) == 0);
      spi_addr  = 7'(8 + c / 2);
      spi_wdata = 8'(8'hE0 + c / 2);
      #1;
      chk("alt_gnt", 8'(eng_gnt), 8'((c % 2) == 0));
      tick();
    end
    spi_we  = 1'b0;
    eng_req = 1'b0;
    tick();
    chk("alt_ovr", 8'(ovr), 8'd0);
    for (int k = 0; k < 10; k++) begin
      eng_read(7'(8 + k), 8'(8'hE0 + k), "alt_mem");
    end

    // Overrun: second write lands while the starved engine owns the slot.
    eng_req  = 1'b1;
    eng_addr = 7'h02;
    spi_addr = 7'h06; spi_wdata = 8'h66; spi_we = 1'b1;
    #1;
    chk("ovr_c0_gnt", 8'(eng_gnt), 8'd1);
    tick();
    spi_addr = 7'h02; spi_wdata = 8'h11;
    #1;
    chk("ovr_c1_gnt", 8'(eng_gnt), 8'd0);
    tick();
    spi_addr = 7'h03; spi_wdata = 8'h22;
    #1;
    chk("ovr_c2_gnt", 8'(eng_gnt), 8'd1);
    chk("ovr_before", 8'(ovr), 8'd0);
    tick();
    spi_we = 1'b0;
    chk("ovr_set", 8'(ovr), 8'd1);
    #1;
    chk("ovr_c3_gnt", 8'(eng_gnt), 8'd0);
    chk("fwd_rvalid", 8'(eng_rvalid), 8'd1);
    chk("fwd_data", eng_rdata, 8'h11);
    tick();
    #1;
    chk("ovr_c4_gnt", 8'(eng_gnt), 8'd1);
    tick();
    eng_req = 1'b0;
    chk("ovr_c4_data", eng_rdata, pat(2));
    eng_read(7'h03, 8'h22, "ovr_newest");
    eng_read(7'h02, pat(2), "ovr_lost");
    eng_read(7'h06, 8'h66, "ovr_first");

    // Request dropped before grant: no read, no rvalid.
    spi_write(7'h07, 8'h70);
    eng_req  = 1'b1;
    eng_addr = 7'h07;
    #1;
    chk("drop_gnt", 8'(eng_gnt), 8'd0);
    tick();
    eng_req = 1'b0;
    chk("drop_rvalid0", 8'(eng_rvalid), 8'd0);
    tick();
    chk("drop_rvalid1", 8'(eng_rvalid), 8'd0);
    eng_read(7'h07, 8'h70, "drop_mem");

    // Reset with a write still pending.
    spi_addr = 7'h07;
    tick();
    spi_write(7'h05, 8'h99);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_spi_rdata", spi_rdata, 8'h00);
    chk("mid_rst_gnt", 8'(eng_gnt), 8'd0);
    chk("mid_rst_rvalid", 8'(eng_rvalid), 8'd0);
    chk("mid_rst_eng_rdata", eng_rdata, 8'h00);
    chk("mid_rst_ovr", 8'(ovr), 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    eng_read(7'h05, 8'h00, "rst_discard");
    eng_read(7'h04, 8'h00, "rst_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
